// File: rtl/bus_master_if_pkg.sv
// Shared constants for the bus master interface unit: bus direction codes,
// FSM state encodings and the timeout counter width helper.
package bus_master_if_pkg;

  // Bus direction codes carried on bus_rw / cpu_rw
  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  // FSM state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] BMI_IDLE   = 3'd0;
  localparam logic [2:0] BMI_REQ    = 3'd1;
  localparam logic [2:0] BMI_ACCESS = 3'd2;
  localparam logic [2:0] BMI_WAIT   = 3'd3;
  localparam logic [2:0] BMI_DONE   = 3'd4;

  // Width of a counter that must reach 'timeout' without wrapping; never below 1 bit
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_master_if_if.sv
// Bus-side signal bundle between a bus master and the arbiter/slave fabric.
// The master modport is the initiator view; the slave modport is the fabric view.
interface bus_master_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);

  logic              bus_req;
  logic              bus_grnt;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic              bus_rdy;
  logic [DATA_W-1:0] bus_rd_data;

  modport master (
    output bus_req,
    output bus_addr,
    output bus_as,
    output bus_rw,
    output bus_wr_data,
    input  bus_grnt,
    input  bus_rdy,
    input  bus_rd_data
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    input  bus_as,
    input  bus_rw,
    input  bus_wr_data,
    output bus_grnt,
    output bus_rdy,
    output bus_rd_data
  );

endinterface

// File: rtl/bus_master_if.sv
// Bus master interface unit: takes one single-word access from the core,
// requests the bus, issues a one-cycle address strobe once granted, waits for
// the slave's ready (with optional timeout) and returns read data to the core.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              cpu_as,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_busy,
  output logic              cpu_err,
  bus_master_if_if.master   bus
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W:0] TIMEOUT_EXT = TIMEOUT[CNT_W:0];

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             timed_out;
  logic             complete;
  logic             abort;

  // Counter arithmetic is one bit wider so saturation and the TIMEOUT compare never see a wrap
  always_comb begin
    cnt_inc   = {1'b0, cnt} + (CNT_W + 1)'(1);
    cnt_sat   = cnt_inc[CNT_W] ? cnt : cnt_inc[CNT_W-1:0];
    timed_out = (TIMEOUT != 0) && (cnt_inc >= TIMEOUT_EXT);
  end

  // Access ends on ready in ACCESS/WAIT; ready wins over a timeout in the same cycle
  always_comb begin
    complete = bus.bus_rdy && ((state == BMI_ACCESS) || (state == BMI_WAIT));
    abort    = !bus.bus_rdy && (state == BMI_WAIT) && timed_out;
  end

  // Core stall: asserted as soon as a request is seen in IDLE, released in DONE
  assign cpu_busy = ((state == BMI_IDLE) && cpu_as) ||
                    (state == BMI_REQ) || (state == BMI_ACCESS) || (state == BMI_WAIT);

  // Access sequencer: latches the request, drives the bus and returns the result
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state           <= BMI_IDLE;
      cnt             <= '0;
      cpu_rd_data     <= '0;
      cpu_err         <= 1'b0;
      bus.bus_req     <= 1'b0;
      bus.bus_as      <= 1'b0;
      bus.bus_rw      <= BUS_READ;
      bus.bus_addr    <= '0;
      bus.bus_wr_data <= '0;
    end else begin
      // Strobe and error are single-cycle pulses unless re-armed below
      bus.bus_as <= 1'b0;
      cpu_err    <= 1'b0;

      case (state)
        BMI_IDLE: begin
          if (cpu_as) begin
            bus.bus_addr    <= cpu_addr;
            bus.bus_rw      <= cpu_rw;
            bus.bus_wr_data <= cpu_wr_data;
            bus.bus_req     <= 1'b1;
            state           <= BMI_REQ;
          end
        end
        BMI_REQ: begin
          // No timeout while waiting for the arbiter
          if (bus.bus_grnt) begin
            bus.bus_as <= 1'b1;
            state      <= BMI_ACCESS;
          end
        end
        BMI_ACCESS: begin
          if (!bus.bus_rdy) begin
            cnt   <= CNT_W'(1);
            state <= BMI_WAIT;
          end
        end
        BMI_WAIT: begin
          if (!bus.bus_rdy) begin
            cnt <= cnt_sat;
          end
        end
        BMI_DONE: begin
          // Single cycle; a still-high cpu_as is deliberately ignored here
          cnt   <= '0;
          state <= BMI_IDLE;
        end
        default: begin
          state <= BMI_IDLE;
        end
      endcase

      if (complete) begin
        bus.bus_req <= 1'b0;
        if (bus.bus_rw != BUS_WRITE) begin
          cpu_rd_data <= bus.bus_rd_data;
        end
        state <= BMI_DONE;
      end

      if (abort) begin
        bus.bus_req <= 1'b0;
        cpu_rd_data <= '0;
        cpu_err     <= 1'b1;
        state       <= BMI_DONE;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: directed cases from the access rules
// plus randomized accesses, each checked against a per-transaction timing model.
module tb_bus_master_if;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rest;
  logic              cpu_as;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_busy;
  logic              cpu_err;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  logic [DATA_W-1:0] model_rd;

  bus_master_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rest        (rest),
    .cpu_as      (cpu_as),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_busy    (cpu_busy),
    .cpu_err     (cpu_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Quiet cycles: no request, noisy cpu inputs, spurious or forced bus_rdy
  task automatic idle_cycles(input int n, input bit force_rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_as           = 1'b0;
      cpu_rw           = 1'($urandom);
      cpu_addr         = ADDR_W'($urandom);
      cpu_wr_data      = DATA_W'($urandom);
      bus.bus_grnt     = 1'b0;
      bus.bus_rdy      = force_rdy ? 1'b1 : 1'($urandom_range(0, 1));
      bus.bus_rd_data  = DATA_W'($urandom);
      #1;
      check_eq("idle_req",  bus.bus_req, 0);
      check_eq("idle_as",   bus.bus_as, 0);
      check_eq("idle_busy", cpu_busy, 0);
      check_eq("idle_err",  cpu_err, 0);
      check_eq("idle_rd",   cpu_rd_data, model_rd);
    end
  endtask

  // One access. Cycle 0 is the IDLE cycle in which cpu_as is first seen.
  // Model: strobe at 2+gdelay; ready arrives 'wstates' cycles after the strobe;
  // DONE one cycle after ready, or TIMEOUT cycles after the strobe on abort.
  task automatic do_access(input logic rw, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                           input int gdelay, input int wstates);
    int exp_a, exp_d, a_seen, d_seen, as_cnt, req_cnt, err_cnt, err_cyc, unstable, req_age;
    bit abort;
    logic [DATA_W-1:0] exp_rd, done_rd;
    abort  = (TIMEOUT != 0) && (wstates >= TIMEOUT);
    exp_a  = 2 + gdelay;
    exp_d  = exp_a + (abort ? TIMEOUT : wstates + 1);
    exp_rd = abort ? '0 : (rw ? rdata : model_rd);
    a_seen = -1; d_seen = -1; as_cnt = 0; req_cnt = 0; err_cnt = 0;
    err_cyc = -1; unstable = 0; req_age = 0; done_rd = '0;
    for (int c = 0; c < 200 && d_seen < 0; c++) begin
      @(negedge clk);
      cpu_as = 1'b1;
      if (c == 0) begin
        cpu_rw = rw; cpu_addr = addr; cpu_wr_data = wdata;
      end else begin
        cpu_rw = 1'($urandom); cpu_addr = ADDR_W'($urandom); cpu_wr_data = DATA_W'($urandom);
      end
      if (bus.bus_as) begin
        as_cnt++;
        if (a_seen < 0) a_seen = c;
      end
      // Arbiter: grant after gdelay request cycles; grant noise after the strobe is harmless
      if (bus.bus_req) req_age++; else req_age = 0;
      bus.bus_grnt = (a_seen >= 0) ? 1'($urandom_range(0, 1)) : (req_age > gdelay);
      // Slave: ready exactly wstates after the strobe; random ready only outside the access
      if (a_seen >= 0 && c - a_seen == wstates) begin
        bus.bus_rdy = 1'b1; bus.bus_rd_data = rdata;
      end else if (a_seen < 0 || c - a_seen > wstates) begin
        bus.bus_rdy = 1'($urandom_range(0, 1)); bus.bus_rd_data = DATA_W'($urandom);
      end else begin
        bus.bus_rdy = 1'b0; bus.bus_rd_data = DATA_W'($urandom);
      end
      #1;
      if (bus.bus_req) req_cnt++;
      if (cpu_err) begin err_cnt++; err_cyc = c; end
      if (c == 0) begin
        check_eq("start_busy", cpu_busy, 1);
      end else begin
        if (bus.bus_addr !== addr || bus.bus_rw !== rw || bus.bus_wr_data !== wdata) unstable++;
        if (!cpu_busy) begin d_seen = c; done_rd = cpu_rd_data; end
      end
    end
    check_eq("done_seen",    d_seen >= 0, 1);
    check_eq("strobe_cycle", a_seen, exp_a);
    check_eq("strobe_count", as_cnt, 1);
    check_eq("done_cycle",   d_seen, exp_d);
    check_eq("req_cycles",   req_cnt, exp_d - 1);
    check_eq("err_count",    err_cnt, abort ? 1 : 0);
    if (abort) check_eq("err_cycle", err_cyc - a_seen, TIMEOUT);
    check_eq("rd_data",      done_rd, exp_rd);
    check_eq("bus_stable",   unstable, 0);
    model_rd = exp_rd;
    txn_no++;
    $display("txn %0d: %s addr=0x%0h grant_delay=%0d wait=%0d strobe@%0d done@%0d rd=0x%0h err=%0d",
             txn_no, rw ? "RD" : "WR", addr, gdelay, wstates, a_seen, d_seen, done_rd, err_cnt);
  endtask

  initial begin
    rest = 1'b0; cpu_as = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    bus.bus_grnt = 1'b0; bus.bus_rdy = 1'b0; bus.bus_rd_data = '0; model_rd = '0;
    #1 rest = 1'b1;
    #1;
    check_eq("rst_req",   bus.bus_req, 0);
    check_eq("rst_as",    bus.bus_as, 0);
    check_eq("rst_err",   cpu_err, 0);
    check_eq("rst_rw",    bus.bus_rw, 1);
    check_eq("rst_addr",  bus.bus_addr, 0);
    check_eq("rst_wdata", bus.bus_wr_data, 0);
    check_eq("rst_rd",    cpu_rd_data, 0);
    check_eq("rst_busy",  cpu_busy, 0);
    repeat (2) @(negedge clk);
    rest = 1'b0;
    idle_cycles(2, 1'b0);

    // Read with immediate grant and zero-wait slave, then a back-to-back read
    do_access(1'b1, 30'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    do_access(1'b1, 30'h20, 32'h0, 32'hCAFEF00D, 1, 1);
    idle_cycles(3, 1'b0);
    // Write with delayed grant and two wait states
    do_access(1'b0, 30'h44, 32'h12345678, 32'hA5A5A5A5, 5, 2);
    idle_cycles(2, 1'b0);
    // Timeout with ready never asserted, then the last-cycle-before-timeout boundary
    do_access(1'b1, 30'h50, 32'h0, 32'h11111111, 0, 1000);
    idle_cycles(2, 1'b0);
    do_access(1'b1, 30'h54, 32'h0, 32'h22222222, 2, TIMEOUT - 1);
    idle_cycles(1, 1'b0);
    do_access(1'b1, 30'h58, 32'h0, 32'h33333333, 0, TIMEOUT);
    idle_cycles(1, 1'b0);

    // Reset in WAIT, applied between clock edges
    @(negedge clk);
    cpu_as = 1'b1; cpu_rw = 1'b1; cpu_addr = 30'h30; cpu_wr_data = '0;
    bus.bus_grnt = 1'b1; bus.bus_rdy = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("pre_rst_busy", cpu_busy, 1);
    @(posedge clk);
    #3;
    rest = 1'b1; cpu_as = 1'b0;
    #1;
    check_eq("async_rst_req",  bus.bus_req, 0);
    check_eq("async_rst_as",   bus.bus_as, 0);
    check_eq("async_rst_busy", cpu_busy, 0);
    check_eq("async_rst_rd",   cpu_rd_data, 0);
    model_rd = '0;
    @(negedge clk);
    rest = 1'b0;
    idle_cycles(4, 1'b1);

    // Randomized accesses, sometimes back-to-back
    for (int t = 0; t < 40; t++) begin
      do_access(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                $urandom_range(0, 6), $urandom_range(0, TIMEOUT + 2));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), 1'b0);
    end
    idle_cycles(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
